output_deskew: RTL and testbench

- Downstream neighbour of the activation skew stage.
- Consumes the time-skewed partial sums leaving the bottom row of the 2x2 systolic array, one stream per column.
- Re-aligns them into a registered 2x2 result matrix and presents it with a valid/ready handshake to the writeback path.
- Optionally accumulates onto the previously held matrix, for K-tiling across successive passes.

---
 rtl/tpu_pkg.sv | 8 +
 rtl/deskew_lane.sv | 46 ++++
 rtl/output_deskew.sv | 117 +++++++++++
 tb/tb_output_deskew.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the 2x2 systolic datapath blocks.
package tpu_pkg;
  localparam int DATA_W_DEFAULT = 16;
  localparam int CAPTURE_CYCLES = 3;
  localparam int PHASE_W = 2;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, HOLD} deskew_state_t;
endpackage

// File: rtl/deskew_lane.sv
// One column of the deskew: captures two successive samples of the column
// stream into top/bottom result registers, overwriting or accumulating.
module deskew_lane
  import tpu_pkg::*;
#(
  parameter int               DATA_W    = DATA_W_DEFAULT,
  parameter logic [PHASE_W-1:0] PHASE_OFS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cap_en,
  input  logic [PHASE_W-1:0] phase,
  input  logic               acc,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  top_o,
  output logic [DATA_W-1:0]  bot_o
);
  localparam logic [PHASE_W-1:0] BOT_PHASE = PHASE_OFS + 1'b1;

  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] bot_q, bot_d;
  logic              top_sel, bot_sel;

  always_comb begin
    top_sel = cap_en && (phase == PHASE_OFS);
    bot_sel = cap_en && (phase == BOT_PHASE);
    top_d   = top_q;
    bot_d   = bot_q;
    // Accumulation wraps modulo 2^DATA_W by construction of the adder width.
    if (top_sel) top_d = acc ? top_q + din : din;
    if (bot_sel) bot_d = acc ? bot_q + din : din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      bot_q <= '0;
    end else begin
      top_q <= top_d;
      bot_q <= bot_d;
    end
  end

  assign top_o = top_q;
  assign bot_o = bot_q;
endmodule

// File: rtl/output_deskew.sv
// Re-aligns the skewed bottom-row column streams into a held 2x2 result
// matrix offered downstream with valid/ready; optional K-tile accumulation.
module output_deskew
  import tpu_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          accumulate,
  input  logic [DATA_W-1:0] col_in1,
  input  logic [DATA_W-1:0] col_in2,
  input  logic          out_ready,
  output logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] c12,
  output logic [DATA_W-1:0] c21,
  output logic [DATA_W-1:0] c22,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output deskew_state_t dbg_state
);
  // Handshake: out_valid is registered and high only in HOLD; a transfer
  // happens on any edge where out_valid && out_ready, after which the state
  // returns to IDLE and out_valid drops. Results never change outside capture.
  localparam logic [3:0]         WAIT_LOAD  = 4'(LATENCY - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CAPTURE_CYCLES - 1);

  deskew_state_t      state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               acc_q, acc_d;
  logic               overrun_q, overrun_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    overrun_d = overrun_q;
    if (start && (state_q != IDLE)) overrun_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = accumulate;
          phase_d = '0;
          if (LATENCY == 1) begin
            state_d = CAPTURE;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = CAPTURE;
          phase_d = '0;
        end
      end
      CAPTURE: begin
        if (phase_q == LAST_PHASE) begin
          state_d = HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      acc_q     <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
    end
  end

  logic cap_en;
  assign cap_en = (state_q == CAPTURE);

  // Column 1 leaves the array one cycle ahead of column 2.
  deskew_lane #(.DATA_W(DATA_W), .PHASE_OFS(PHASE_W'(0))) u_lane1 (
    .clk(clk), .rst_n(reset), .cap_en(cap_en), .phase(phase_q), .acc(acc_q),
    .din(col_in1), .top_o(c11), .bot_o(c21)
  );

  deskew_lane #(.DATA_W(DATA_W), .PHASE_OFS(PHASE_W'(1))) u_lane2 (
    .clk(clk), .rst_n(reset), .cap_en(cap_en), .phase(phase_q), .acc(acc_q),
    .din(col_in2), .top_o(c12), .bot_o(c22)
  );

  assign out_valid = valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_output_deskew.sv
// Directed scoreboard bench for output_deskew (LATENCY=3 and LATENCY=1 builds).
module tb_output_deskew;
  import tpu_pkg::*;
  localparam int W = 16;
  localparam logic [W-1:0] DEAD = 16'hDEAD;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // shared stimulus, steered to one DUT by sel
  logic sel, out_ready, s_start, s_acc;
  logic [W-1:0] s_c1, s_c2;

  logic [W-1:0] d0_c11, d0_c12, d0_c21, d0_c22, d1_c11, d1_c12, d1_c21, d1_c22;
  logic d0_v, d0_busy, d0_ovr, d1_v, d1_busy, d1_ovr;
  deskew_state_t d0_st, d1_st;

  output_deskew #(.DATA_W(W), .LATENCY(3)) u_dut (
    .clk(clk), .reset(reset), .start(s_start && !sel), .accumulate(s_acc),
    .col_in1(s_c1), .col_in2(s_c2), .out_ready(out_ready),
    .c11(d0_c11), .c12(d0_c12), .c21(d0_c21), .c22(d0_c22),
    .out_valid(d0_v), .busy(d0_busy), .overrun(d0_ovr), .dbg_state(d0_st)
  );

  output_deskew #(.DATA_W(W), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .start(s_start && sel), .accumulate(s_acc),
    .col_in1(s_c1), .col_in2(s_c2), .out_ready(out_ready),
    .c11(d1_c11), .c12(d1_c12), .c21(d1_c21), .c22(d1_c22),
    .out_valid(d1_v), .busy(d1_busy), .overrun(d1_ovr), .dbg_state(d1_st)
  );

  logic [63:0] m_res;
  logic m_valid, m_busy, m_ovr;
  assign m_res   = sel ? {d1_c11, d1_c12, d1_c21, d1_c22} : {d0_c11, d0_c12, d0_c21, d0_c22};
  assign m_valid = sel ? d1_v : d0_v;
  assign m_busy  = sel ? d1_busy : d0_busy;
  assign m_ovr   = sel ? d1_ovr : d0_ovr;

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] m11, m12, m21, m22;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (reset && m_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_transfer actual=%h required=none", m_res);
      end else begin
        e = exp_q.pop_front();
        chk("transfer_result", m_res, e);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int lat, input logic acc,
                          input logic [W-1:0] v11, input logic [W-1:0] v21,
                          input logic [W-1:0] v12, input logic [W-1:0] v22);
    if (acc) begin
      m11 = m11 + v11; m21 = m21 + v21; m12 = m12 + v12; m22 = m22 + v22;
    end else begin
      m11 = v11; m21 = v21; m12 = v12; m22 = v22;
    end
    exp_q.push_back({m11, m12, m21, m22});
    for (int k = 0; k <= lat + 3; k++) begin
      s_start = (k == 0);
      s_acc   = acc;
      s_c1    = (k == lat) ? v11 : (k == lat + 1) ? v21 : DEAD;
      s_c2    = (k == lat + 1) ? v12 : (k == lat + 2) ? v22 : DEAD;
      @(negedge clk);
      chk($sformatf("valid_cycle%0d", k), 64'(m_valid), 64'(k == lat + 3));
      if (k > 0) chk($sformatf("busy_cycle%0d", k), 64'(m_busy), 64'd1);
      step();
    end
    s_start = 1'b0;
    s_c1 = DEAD;
    s_c2 = DEAD;
  endtask

  task automatic chk_idle(input string name, input logic [63:0] req);
    @(negedge clk);
    chk({name, "_valid"}, 64'(m_valid), 64'd0);
    chk({name, "_res"}, m_res, req);
    step();
  endtask

  initial begin
    sel = 1'b0; reset = 1'b0; out_ready = 1'b1;
    s_start = 1'b0; s_acc = 1'b0; s_c1 = DEAD; s_c2 = DEAD;
    m11 = '0; m12 = '0; m21 = '0; m22 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_res", m_res, 64'd0);
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_busy", 64'(m_busy), 64'd0);
    chk("reset_overrun", 64'(m_ovr), 64'd0);
    chk("reset_state", 64'(d0_st), 64'(IDLE));
    reset = 1'b1;
    step();

    // basic, then two accumulating passes (second one wraps)
    run_pass(3, 1'b0, 16'd19, 16'd43, 16'd22, 16'd50);
    chk_idle("basic_idle", {16'd19, 16'd22, 16'd43, 16'd50});
    run_pass(3, 1'b1, 16'd19, 16'd43, 16'd22, 16'd50);
    chk_idle("acc_idle", {16'd38, 16'd44, 16'd86, 16'd100});
    run_pass(3, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk_idle("wrap_idle", {16'd37, 16'd43, 16'd85, 16'd99});

    // backpressure with a stray start during HOLD
    out_ready = 1'b0;
    run_pass(3, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 10; i++) begin
      s_start = (i == 3);
      @(negedge clk);
      chk("bp_valid", 64'(m_valid), 64'd1);
      chk("bp_res", m_res, {16'h1111, 16'h3333, 16'h2222, 16'h4444});
      if (i == 0) chk("bp_overrun_clear", 64'(m_ovr), 64'd0);
      if (i == 4) chk("bp_overrun_set", 64'(m_ovr), 64'd1);
      step();
    end
    s_start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    step();

    // back-to-back: start the cycle after the handshake
    run_pass(3, 1'b0, 16'd1, 16'd2, 16'd3, 16'd4);
    @(negedge clk);
    chk("b2b_res", m_res, {16'd1, 16'd3, 16'd2, 16'd4});
    chk("overrun_sticky", 64'(m_ovr), 64'd1);
    chk("b2b_busy", 64'(m_busy), 64'd0);
    step();

    // reset during CAPTURE phase 1
    for (int k = 0; k <= 4; k++) begin
      s_start = (k == 0);
      s_acc = 1'b1;
      s_c1 = (k == 3) ? 16'h0777 : DEAD;
      s_c2 = DEAD;
      if (k == 4) begin
        reset = 1'b0;
        #1;
        chk("midreset_res", m_res, 64'd0);
        chk("midreset_valid", 64'(m_valid), 64'd0);
        chk("midreset_busy", 64'(m_busy), 64'd0);
        chk("midreset_overrun", 64'(m_ovr), 64'd0);
      end else begin
        step();
      end
    end
    s_start = 1'b0; s_c1 = DEAD;
    m11 = '0; m12 = '0; m21 = '0; m22 = '0;
    step();
    reset = 1'b1;
    step();
    run_pass(3, 1'b0, 16'd19, 16'd43, 16'd22, 16'd50);
    chk_idle("post_reset_idle", {16'd19, 16'd22, 16'd43, 16'd50});

    // LATENCY=1 build
    sel = 1'b1;
    step();
    run_pass(1, 1'b0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    chk_idle("lat1_idle", {16'h0A0A, 16'h0C0C, 16'h0B0B, 16'h0D0D});

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
